sub_bytes_seq: RTL and testbench
================================

Name: sub_bytes_seq

Overview:
- Encryption-side SubBytes engine for the optimised AES datapath; the forward counterpart of the per-byte inverse S-box block used in decryption.
- Accepts a full 128-bit AES state over a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock through forward S-box lookups, so area scales with throughput.
- Returns the substituted state over a second valid/ready handshake to the ShiftRows stage.

Parameters:
- BYTES_PER_CYCLE, 1, bytes substituted per clock. Legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- NCYC, 16/BYTES_PER_CYCLE (localparam), substitution cycles per block.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block can accept a state.
- in_state  in  128  input AES state. Byte 0 = [127:120], byte 15 = [7:0].
- out_valid  out  1  out_state holds the completed SubBytes result.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  substituted state, same byte order as in_state.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (rst high at a clk edge): FSM=IDLE, byte counter=0, state register=0, out_valid=0, out_state=0, busy=0.
  - Reset mid-operation abandons the block; no partial result is ever flagged valid.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load the state register with in_state, counter=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each edge replaces bytes [counter*BPC .. counter*BPC+BPC-1] with S(byte), processing MSB byte first, then counter++.
  - On the edge where counter==NCYC-1: go to DONE.
- DONE:
  - out_valid=1; out_state = state register, held stable until the handshake.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE, so the next accept is the cycle after returning to IDLE.
- Latency: out_valid is high exactly NCYC cycles after the accepting edge (16 cycles for BPC=1, 1 cycle for BPC=16).
  - Minimum block period is NCYC+2 cycles when out_ready is tied high.
- out_state is driven only from the state register.
  - It must show 0 after reset and the last result after DONE→IDLE; the register is not cleared on exit.
- Counter width is clog2(NCYC), minimum 1 bit. It never wraps past NCYC-1.
- in_valid while in_ready=0 is ignored; the upstream holds data per the handshake contract.
- Stalls: out_ready may stay low indefinitely; the block holds DONE with no change.
- The S-box is purely combinational. The only registers are FSM, counter and state register.
- The S-box table is the FIPS-197 forward table. Every one of the 256 entries is defined; no X default.

Decomposition:
- Shared package aes_pkg:
  - AES_STATE_W=128, AES_NUM_BYTES=16.
  - byte typedef.
  - FSM state enum {IDLE, BUSY, DONE}.
- One sub-module, sbox_fwd: 8-bit combinational forward S-box LUT.
  - Instantiated BYTES_PER_CYCLE times in a generate loop, each fed by a byte mux indexed by counter.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release → out_valid=0, out_state=0, in_ready=1, busy=0.
- Known vector, BPC=1: in_state=00112233445566778899aabbccddeeff, out_ready=1.
  - Expect out_state=638293c31bfc33f5c4eeacea4bc12816.
  - out_valid rises exactly 16 cycles after accept.
  - in_ready=0 throughout.
- Single-byte spot values: in_state=00 01 53 ff, repeated ×4.
  - Expect 63 7c ed 16, repeated ×4.
  - Repeat for BPC=2, 4, 16; check latency = 8, 4, 1 cycles respectively.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and out_state stable. Pulse in_valid with new data during the stall → not accepted. Raise out_ready → IDLE next cycle, then accept.
- Reset mid-operation: assert rst at counter=7 → IDLE next edge, out_valid never asserted. Run the next block normally → correct result.
- Round trip / exhaustive: 256 random states, each byte passed through the inverse S-box table → identity. All 256 byte values covered across the states.

Source files
------------

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared types and sizes for the AES datapath blocks.
//   AES_STATE_W   : width of a full AES state in bits
//   AES_NUM_BYTES : bytes per AES state
//   aes_byte_t    : one state byte
//   sb_state_e    : SubBytes sequencer FSM states
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_STATE_W   = 128;
    localparam int AES_NUM_BYTES = 16;

    typedef logic [7:0] aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_state_e;

endpackage

// File: rtl/sbox_fwd.sv
// ----------------------------------------------------------------------------
// sbox_fwd
// Purely combinational forward AES S-box (FIPS-197 table), all 256 entries.
// Ports:
//   byte_val : input byte
//   sub_val  : substituted byte S(byte_val)
// ----------------------------------------------------------------------------
module sbox_fwd
    import aes_pkg::*;
(
    input  aes_byte_t byte_val,
    output aes_byte_t sub_val
);

    // Row r holds S(16r) .. S(16r+15), entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry n sits at bit offset 8*(255-n); ~n equals 255-n for an 8-bit n.
    logic [10:0] tbl_ofs;

    assign tbl_ofs = {~byte_val, 3'b000};
    assign sub_val = SBOX_TABLE[tbl_ofs +: 8];

endmodule

// File: rtl/sub_bytes_seq.sv
// ----------------------------------------------------------------------------
// sub_bytes_seq
// Encryption-side SubBytes engine. Takes a 128-bit AES state over a
// valid/ready handshake, substitutes BYTES_PER_CYCLE bytes per clock through
// forward S-box lanes (MSB byte first) and returns the result over a second
// valid/ready handshake.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_state is valid
//   in_ready  : block can accept a state (IDLE only)
//   in_state  : input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid : out_state holds the completed result (DONE only)
//   out_ready : downstream accepts out_state
//   out_state : state register contents, same byte order as in_state
//   busy      : high in BUSY or DONE
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// BUSY  | substituting BYTES_PER_CYCLE bytes per clock, counter selects slice
// DONE  | result held on out_state with out_valid high until out_ready
// ----------------------------------------------------------------------------
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int NCYC  = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bpc_illegal
        $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    sb_state_e              fsm_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_STATE_W-1:0] state_q;
    logic [AES_STATE_W-1:0] state_nxt;

    aes_byte_t lane_in  [BYTES_PER_CYCLE];
    aes_byte_t lane_out [BYTES_PER_CYCLE];

    // Byte k of the state lives at bit offset 8*(AES_NUM_BYTES-1-k); the
    // counter picks which BYTES_PER_CYCLE-wide slice the lanes see.
    always_comb begin
        int byte_idx;
        byte_idx = 0;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            byte_idx   = int'(cnt_q) * BYTES_PER_CYCLE + j;
            lane_in[j] = state_q[8*(AES_NUM_BYTES-1-byte_idx) +: 8];
        end
    end

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
        sbox_fwd u_sbox (
            .byte_val (lane_in[j]),
            .sub_val  (lane_out[j])
        );
    end

    always_comb begin
        int byte_idx;
        byte_idx  = 0;
        state_nxt = state_q;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            byte_idx = int'(cnt_q) * BYTES_PER_CYCLE + j;
            state_nxt[8*(AES_NUM_BYTES-1-byte_idx) +: 8] = lane_out[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            cnt_q     <= '0;
            state_q   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= in_state;
                        cnt_q    <= '0;
                        fsm_q    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    state_q <= state_nxt;
                    // Counter holds at its terminal value; it is reloaded on
                    // the next accept.
                    if (cnt_q == CNT_LAST) begin
                        fsm_q     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // state_q is kept so out_state shows the last result in IDLE.
                    if (out_ready) begin
                        fsm_q     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_state = state_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [3:0]   busy;
    logic [127:0] in_state  [4];
    logic [127:0] out_state [4];

    int n_checks;
    int n_errors;

    logic [7:0] sbox_ref [256];
    logic [7:0] inv_ref  [256];
    int         lat_tab  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
        sub_bytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S(x) = affine(x^-1), with 0 mapping to inverse 0
    task automatic build_ref();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_ref[x] = s;
        end
        for (int x = 0; x < 256; x++) inv_ref[sbox_ref[x]] = 8'(x);
    endtask

    function automatic logic [127:0] sub_ref(input logic [127:0] st);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = sbox_ref[st[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_ref(input logic [127:0] st);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = inv_ref[st[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept a block on DUT k, wait for out_valid, check latency and result.
    // Leaves time at posedge+1 with out_valid high (unless timed out).
    task automatic start_and_wait(input int k, input logic [127:0] data, input string tag);
        int lat;
        logic rdy_low;
        chk({tag, "_in_ready_idle"}, 128'(in_ready[k]), 128'(1));
        in_state[k] = data;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        lat = 0;
        rdy_low = 1'b1;
        while (!out_valid[k] && lat < 100) begin
            if (in_ready[k] !== 1'b0) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(lat_tab[k]));
        chk({tag, "_in_ready_low"}, 128'(rdy_low & ~in_ready[k]), 128'(1));
        chk({tag, "_result"}, out_state[k], sub_ref(data));
    endtask

    task automatic finish_handshake(input int k, input string tag);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_out_valid_drop"}, 128'(out_valid[k]), 128'(0));
        chk({tag, "_in_ready_back"}, 128'(in_ready[k]), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] held, data, res;
        logic         stable;
        logic [255:0] seen;
        int           covered, k;

        n_checks = 0;
        n_errors = 0;
        lat_tab  = '{16, 8, 4, 1};
        build_ref();

        rst       = 1'b1;
        in_valid  = 4'h0;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) in_state[i] = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_valid", 128'(out_valid[i]), 128'(0));
            chk("rst_out_state", out_state[i], 128'(0));
            chk("rst_in_ready",  128'(in_ready[i]), 128'(1));
            chk("rst_busy",      128'(busy[i]), 128'(0));
        end

        // Known FIPS-197 style vector on BPC=1
        start_and_wait(0, 128'h00112233445566778899aabbccddeeff, "kv");
        chk("kv_const", out_state[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
        chk("kv_busy", 128'(busy[0]), 128'(1));
        finish_handshake(0, "kv");
        chk("kv_hold_after_idle", out_state[0], 128'h638293c31bfc33f5c4eeacea4bc12816);
        chk("kv_busy_idle", 128'(busy[0]), 128'(0));

        // Spot values on every lane width
        for (int i = 0; i < 4; i++) begin
            start_and_wait(i, {4{32'h000153ff}}, "spot");
            chk("spot_const", out_state[i], {4{32'h637ced16}});
            finish_handshake(i, "spot");
        end

        // Backpressure with a stray in_valid pulse during the stall
        out_ready[0] = 1'b0;
        data = rand128();
        start_and_wait(0, data, "bp");
        held   = out_state[0];
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                in_state[0] = ~data;
                in_valid[0] = 1'b1;
            end else begin
                in_valid[0] = 1'b0;
            end
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b1 || out_state[0] !== held || in_ready[0] !== 1'b0)
                stable = 1'b0;
        end
        in_valid[0] = 1'b0;
        chk("bp_stable", 128'(stable), 128'(1));
        finish_handshake(0, "bp");
        chk("bp_kept_result", out_state[0], sub_ref(data));
        data = rand128();
        start_and_wait(0, data, "bp_next");
        finish_handshake(0, "bp_next");

        // Reset after 7 substitution edges
        in_state[0] = rand128();
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        stable = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) stable = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_no_valid", 128'(stable & ~out_valid[0]), 128'(1));
        chk("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
        chk("mid_rst_busy",     128'(busy[0]), 128'(0));
        chk("mid_rst_state",    out_state[0], 128'(0));
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) stable = 1'b0;
        end
        chk("mid_rst_quiet", 128'(stable), 128'(1));
        data = rand128();
        start_and_wait(0, data, "post_rst");
        finish_handshake(0, "post_rst");

        // Round trip over 256 random states; byte 0 sweeps all values
        seen = '0;
        for (int i = 0; i < 256; i++) begin
            k    = i % 4;
            data = rand128();
            data[127:120] = 8'(i);
            start_and_wait(k, data, "rt");
            res = out_state[k];
            chk("rt_inverse", inv_sub_ref(res), data);
            for (int b = 0; b < 16; b++) seen[data[8*b +: 8]] = 1'b1;
            finish_handshake(k, "rt");
        end
        covered = 0;
        for (int v = 0; v < 256; v++) if (seen[v]) covered++;
        chk("rt_coverage", 128'(covered), 128'(256));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
